// File: rtl/dualclk_fifos.sv
// Single-clock FIFO: 16-bit words in, 8-bit bytes out (low byte first).
// 256-word storage; the state is a byte count plus one write and one read pointer.
module dualclk_fifos (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data,
    input  logic        wrreq,
    input  logic        rdreq,
    output logic [7:0]  q,
    output logic        rdempty,
    output logic [8:0]  rdusedw,
    output logic        wrfull,
    output logic [7:0]  wrusedw
);

    logic [15:0] mem [256];
    logic [7:0]  wp;
    logic [8:0]  rp;
    logic [9:0]  bcnt;
    logic [9:0]  bnext;
    logic [8:0]  occ;
    logic        wr_ok;
    logic        rd_ok;
    logic [15:0] rword;

    // A half-read word still occupies its slot, so words = ceil(bytes / 2).
    assign occ     = 9'((bcnt + 10'd1) >> 1);
    assign wrfull  = occ[8];
    assign rdempty = (bcnt == '0);
    assign rdusedw = bcnt[8:0];
    assign wrusedw = occ[7:0];

    assign wr_ok = wrreq && !wrfull;
    assign rd_ok = rdreq && !rdempty;
    assign rword = mem[rp[8:1]];

    always_comb begin
        bnext = bcnt;
        if (wr_ok) bnext = bnext + 10'd2;
        if (rd_ok) bnext = bnext - 10'd1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok && rst_n) mem[wp] <= data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp   <= '0;
            rp   <= '0;
            bcnt <= '0;
            q    <= '0;
        end else begin
            bcnt <= bnext;
            if (wr_ok) wp <= wp + 8'd1;
            if (rd_ok) begin
                rp <= rp + 9'd1;
                q  <= rp[0] ? rword[15:8] : rword[7:0];
            end
        end
    end

endmodule

// File: tb/tb_dualclk_fifos.sv
// Directed self-checking bench for dualclk_fifos.
module tb_dualclk_fifos;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic        wrreq;
    logic        rdreq;
    logic [7:0]  q;
    logic        rdempty;
    logic [8:0]  rdusedw;
    logic        wrfull;
    logic [7:0]  wrusedw;

    int unsigned ntests = 0;
    int unsigned nfail  = 0;

    dualclk_fifos dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .wrreq   (wrreq),
        .rdreq   (rdreq),
        .q       (q),
        .rdempty (rdempty),
        .rdusedw (rdusedw),
        .wrfull  (wrfull),
        .wrusedw (wrusedw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".rdempty"}, 32'(rdempty), 32'd1);
        check({tag, ".wrfull"},  32'(wrfull),  32'd0);
        check({tag, ".rdusedw"}, 32'(rdusedw), 32'd0);
        check({tag, ".wrusedw"}, 32'(wrusedw), 32'd0);
        check({tag, ".q"},       32'(q),       32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        data  = '0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_reset_state("idle");

        // Fill with words 0..255
        wrreq = 1'b1;
        for (int k = 0; k < 256; k++) begin
            data = 16'(k);
            tick();
            check("fill.wrusedw", 32'(wrusedw), 32'((k + 1) % 256));
            check("fill.rdusedw", 32'(rdusedw), 32'((2 * (k + 1)) % 512));
        end
        check("full.wrfull",  32'(wrfull),  32'd1);
        check("full.rdempty", 32'(rdempty), 32'd0);

        // Write into a full FIFO must be ignored
        data = 16'hBEEF;
        tick();
        check("ovf.wrfull",  32'(wrfull),  32'd1);
        check("ovf.wrusedw", 32'(wrusedw), 32'd0);
        check("ovf.rdusedw", 32'(rdusedw), 32'd0);
        wrreq = 1'b0;

        // Drain 512 bytes: k, 0 for each word
        rdreq = 1'b1;
        for (int i = 0; i < 512; i++) begin
            tick();
            check("drain.q",       32'(q),       (i % 2 == 0) ? 32'(i / 2) : 32'd0);
            check("drain.rdusedw", 32'(rdusedw), 32'((511 - i) % 512));
            check("drain.wrfull",  32'(wrfull),  (i == 0) ? 32'd1 : 32'd0);
        end
        check("drain.rdempty", 32'(rdempty), 32'd1);
        rdreq = 1'b0;

        // Simultaneous read and write
        wrreq = 1'b1;
        data  = 16'h1234;
        tick();
        check("one.rdusedw", 32'(rdusedw), 32'd2);
        rdreq = 1'b1;
        data  = 16'h5678;
        tick();
        check("rw.q",       32'(q),       32'h34);
        check("rw.rdusedw", 32'(rdusedw), 32'd3);
        check("rw.wrusedw", 32'(wrusedw), 32'd2);
        wrreq = 1'b0;
        tick();
        check("rw.b1", 32'(q), 32'h12);
        tick();
        check("rw.b2", 32'(q), 32'h78);
        tick();
        check("rw.b3", 32'(q), 32'h56);
        check("rw.rdempty", 32'(rdempty), 32'd1);

        // Read on empty holds q
        tick();
        check("udf.q",       32'(q),       32'h56);
        check("udf.rdusedw", 32'(rdusedw), 32'd0);
        rdreq = 1'b0;

        // Reset mid-transfer beats a concurrent write
        wrreq = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data = 16'hA000 + 16'(k);
            tick();
        end
        wrreq = 1'b0;
        rdreq = 1'b1;
        tick();
        check("mid.q0", 32'(q), 32'h00);
        tick();
        check("mid.q1", 32'(q), 32'hA0);
        tick();
        check("mid.q2", 32'(q), 32'h01);
        rdreq = 1'b0;
        check("mid.rdusedw", 32'(rdusedw), 32'd17);
        check("mid.wrusedw", 32'(wrusedw), 32'd9);
        rst_n = 1'b0;
        wrreq = 1'b1;
        data  = 16'hCAFE;
        tick();
        check_reset_state("rst");
        rst_n = 1'b1;
        wrreq = 1'b0;
        tick();
        check_reset_state("post");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
